// File: rtl/debounce_pkg.sv
// Shared state encoding and state-decode helpers for the switch debouncer
// and its edge detectors.
package debounce_pkg;

    localparam logic [1:0] ZERO  = 2'd0;
    localparam logic [1:0] WAIT1 = 2'd1;
    localparam logic [1:0] ONE   = 2'd2;
    localparam logic [1:0] WAIT0 = 2'd3;

    typedef enum logic [1:0] {
        ST_ZERO  = ZERO,
        ST_WAIT1 = WAIT1,
        ST_ONE   = ONE,
        ST_WAIT0 = WAIT0
    } state_e;

    // True while a level change is being qualified
    function automatic logic is_wait(input state_e st);
        return (st == ST_WAIT1) || (st == ST_WAIT0);
    endfunction

    // True whenever the accepted level is high
    function automatic logic is_high(input state_e st);
        return (st == ST_ONE) || (st == ST_WAIT0);
    endfunction

endpackage

// File: rtl/debounce_stable_counter.sv
// Saturating stability counter; done flags the last sample before acceptance.
module debounce_stable_counter #(
    parameter int STABLE_TICKS = 10
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic inc,
    output logic done
);

    localparam int            CW   = (STABLE_TICKS > 1) ? $clog2(STABLE_TICKS) : 1;
    localparam logic [CW-1:0] TERM = CW'(STABLE_TICKS - 1);

    logic [CW-1:0] count_r;

    // Count consecutive qualifying samples; holding at TERM keeps it from wrapping
    always_ff @(posedge clk) begin
        if (reset) begin
            count_r <= {CW{1'b0}};
        end else if (clear) begin
            count_r <= {CW{1'b0}};
        end else if (inc && (count_r != TERM)) begin
            count_r <= count_r + CW'(1);
        end else begin
            count_r <= count_r;
        end
    end

    assign done = (count_r == TERM);

endmodule

// File: rtl/debounce_edge_fsm.sv
// Switch debouncer: a level is accepted after STABLE_TICKS+1 consecutive enabled
// samples; one-cycle rise/fall ticks mark each accepted transition.
module debounce_edge_fsm
    import debounce_pkg::*;
#(
    parameter int STABLE_TICKS = 10
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    input  logic noisy,
    output logic debounced,
    output logic rise_tick,
    output logic fall_tick,
    output logic busy
);

    state_e state_r;
    logic   debounced_r;
    logic   rise_r;
    logic   fall_r;
    logic   clear_s;
    logic   inc_s;
    logic   done_s;

    debounce_stable_counter #(
        .STABLE_TICKS(STABLE_TICKS)
    ) u_counter (
        .clk  (clk),
        .reset(reset),
        .clear(clear_s),
        .inc  (inc_s),
        .done (done_s)
    );

    // Counter control: restart on leaving a stable state, advance while the new level persists
    always_comb begin
        clear_s = 1'b0;
        inc_s   = 1'b0;
        if (en) begin
            case (state_r)
                ST_ZERO:  clear_s = noisy;
                ST_WAIT1: inc_s   = noisy;
                ST_ONE:   clear_s = ~noisy;
                ST_WAIT0: inc_s   = ~noisy;
                default: begin
                    clear_s = 1'b0;
                    inc_s   = 1'b0;
                end
            endcase
        end else begin
            clear_s = 1'b0;
            inc_s   = 1'b0;
        end
    end

    // Debounce FSM with registered level and tick outputs; ticks self-clear every cycle
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= ST_ZERO;
            debounced_r <= 1'b0;
            rise_r      <= 1'b0;
            fall_r      <= 1'b0;
        end else begin
            rise_r <= 1'b0;
            fall_r <= 1'b0;
            if (en) begin
                case (state_r)
                    ST_ZERO: begin
                        if (noisy) begin
                            state_r <= ST_WAIT1;
                        end
                    end
                    ST_WAIT1: begin
                        if (!noisy) begin
                            state_r <= ST_ZERO;
                        end else if (done_s) begin
                            state_r     <= ST_ONE;
                            debounced_r <= 1'b1;
                            rise_r      <= 1'b1;
                        end
                    end
                    ST_ONE: begin
                        if (!noisy) begin
                            state_r <= ST_WAIT0;
                        end
                    end
                    ST_WAIT0: begin
                        if (noisy) begin
                            state_r <= ST_ONE;
                        end else if (done_s) begin
                            state_r     <= ST_ZERO;
                            debounced_r <= 1'b0;
                            fall_r      <= 1'b1;
                        end
                    end
                    default: begin
                        state_r     <= ST_ZERO;
                        debounced_r <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign debounced = debounced_r;
    assign rise_tick = rise_r;
    assign fall_tick = fall_r;
    assign busy      = is_wait(state_r);

endmodule

// File: tb/tb_debounce_edge_fsm.sv
// Scoreboard bench for debounce_edge_fsm at STABLE_TICKS=10 (dut a) and 2 (dut b);
// stimulus queues expected tick events, negedge monitors pop and compare them.
module tb_debounce_edge_fsm;

    typedef struct {
        bit is_rise;
        int cyc;
    } ev_t;

    logic clk = 1'b0;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    int   p;
    int   busy_seen;
    ev_t  qa[$];
    ev_t  qb[$];
    ev_t  ea;
    ev_t  eb;

    logic a_reset = 1'b1, a_en = 1'b0, a_noisy = 1'b0;
    logic a_deb, a_rise, a_fall, a_busy;
    logic b_reset = 1'b1, b_en = 1'b0, b_noisy = 1'b0;
    logic b_deb, b_rise, b_fall, b_busy;

    debounce_edge_fsm #(.STABLE_TICKS(10)) u_dut_a (
        .clk(clk), .reset(a_reset), .en(a_en), .noisy(a_noisy),
        .debounced(a_deb), .rise_tick(a_rise), .fall_tick(a_fall), .busy(a_busy)
    );

    debounce_edge_fsm #(.STABLE_TICKS(2)) u_dut_b (
        .clk(clk), .reset(b_reset), .en(b_en), .noisy(b_noisy),
        .debounced(b_deb), .rise_tick(b_rise), .fall_tick(b_fall), .busy(b_busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic adv(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Monitor for dut a: every presented tick must match the head of its queue
    always @(negedge clk) begin
        chk("a_tick_overlap", int'(a_rise && a_fall), 0);
        if (a_rise || a_fall) begin
            if (qa.size() == 0) begin
                chk("a_unexpected_tick", 1, 0);
            end else begin
                ea = qa.pop_front();
                chk("a_tick_kind", int'(a_rise), int'(ea.is_rise));
                chk("a_tick_cycle", cyc, ea.cyc);
            end
        end
    end

    // Monitor for dut b
    always @(negedge clk) begin
        chk("b_tick_overlap", int'(b_rise && b_fall), 0);
        if (b_rise || b_fall) begin
            if (qb.size() == 0) begin
                chk("b_unexpected_tick", 1, 0);
            end else begin
                eb = qb.pop_front();
                chk("b_tick_kind", int'(b_rise), int'(eb.is_rise));
                chk("b_tick_cycle", cyc, eb.cyc);
            end
        end
    end

    initial begin
        adv(3);
        chk("a_rst_debounced", a_deb, 0);
        chk("a_rst_rise", a_rise, 0);
        chk("a_rst_fall", a_fall, 0);
        chk("a_rst_busy", a_busy, 0);
        chk("b_rst_debounced", b_deb, 0);

        // Steady high from the first post-reset edge: accepted after 11 samples
        a_reset = 1'b0; a_en = 1'b1; a_noisy = 1'b1; p = cyc;
        qa.push_back('{is_rise: 1'b1, cyc: p + 11});
        adv(10);
        chk("a_s1_deb_before", a_deb, 0);
        chk("a_s1_busy_waiting", a_busy, 1);
        adv(1);
        chk("a_s1_deb_after", a_deb, 1);
        chk("a_s1_busy_idle", a_busy, 0);
        adv(2);

        // Reset from ONE drops the level without a fall tick
        a_reset = 1'b1;
        adv(1);
        chk("a_s2_rst_deb", a_deb, 0);
        // 6 high, 1 low, then steady high: count restarts at re-entry
        a_reset = 1'b0; a_noisy = 1'b1;
        adv(6);
        chk("a_s2_busy_mid", a_busy, 1);
        a_noisy = 1'b0;
        adv(1);
        chk("a_s2_aborted_busy", a_busy, 0);
        chk("a_s2_aborted_deb", a_deb, 0);
        a_noisy = 1'b1; p = cyc;
        qa.push_back('{is_rise: 1'b1, cyc: p + 11});
        adv(10);
        chk("a_s2_deb_before", a_deb, 0);
        adv(1);
        chk("a_s2_deb_after", a_deb, 1);
        adv(2);

        // Toggling every 3 cycles from ONE never qualifies a low level
        busy_seen = 0;
        for (int i = 0; i < 40; i++) begin
            a_noisy = (((i / 3) % 2) == 0) ? 1'b0 : 1'b1;
            adv(1);
            chk("a_s3_deb_held", a_deb, 1);
            if (a_busy) busy_seen++;
        end
        chk("a_s3_busy_pulsed", int'(busy_seen > 0), 1);
        chk("a_s3_busy_not_stuck", int'(busy_seen < 40), 1);
        adv(2);

        // Genuine release
        a_noisy = 1'b0; p = cyc;
        qa.push_back('{is_rise: 1'b0, cyc: p + 11});
        adv(10);
        chk("a_fall_deb_before", a_deb, 1);
        adv(1);
        chk("a_fall_deb_after", a_deb, 0);
        adv(2);

        // en low for 5 cycles at count 4 delays acceptance by 5
        a_noisy = 1'b1; p = cyc;
        qa.push_back('{is_rise: 1'b1, cyc: p + 16});
        adv(5);
        chk("a_s4_busy_pre", a_busy, 1);
        a_en = 1'b0; a_noisy = 1'b0;
        adv(5);
        chk("a_s4_busy_hold", a_busy, 1);
        chk("a_s4_deb_hold", a_deb, 0);
        a_en = 1'b1; a_noisy = 1'b1;
        adv(5);
        chk("a_s4_deb_before", a_deb, 0);
        adv(1);
        chk("a_s4_deb_after", a_deb, 1);
        adv(2);

        // Reset at count 8 of WAIT1 abandons the count
        a_reset = 1'b1;
        adv(1);
        chk("a_s5_rst1_deb", a_deb, 0);
        a_reset = 1'b0;
        adv(9);
        chk("a_s5_busy_count8", a_busy, 1);
        a_reset = 1'b1;
        adv(1);
        chk("a_s5_rst2_deb", a_deb, 0);
        chk("a_s5_rst2_busy", a_busy, 0);
        a_reset = 1'b0; p = cyc;
        qa.push_back('{is_rise: 1'b1, cyc: p + 11});
        adv(10);
        chk("a_s5_deb_before", a_deb, 0);
        adv(1);
        chk("a_s5_deb_after", a_deb, 1);
        adv(3);

        // STABLE_TICKS=2: 3 stable samples accept, 2-sample glitches are rejected
        b_reset = 1'b0; b_en = 1'b1; b_noisy = 1'b0;
        adv(2);
        chk("b_idle_deb", b_deb, 0);
        b_noisy = 1'b1;
        adv(2);
        b_noisy = 1'b0;
        adv(1);
        chk("b_glitch_hi_busy", b_busy, 0);
        adv(2);
        chk("b_glitch_hi_deb", b_deb, 0);
        b_noisy = 1'b1; p = cyc;
        qb.push_back('{is_rise: 1'b1, cyc: p + 3});
        adv(2);
        chk("b_rise_deb_before", b_deb, 0);
        adv(1);
        chk("b_rise_deb_after", b_deb, 1);
        b_noisy = 1'b0;
        adv(2);
        b_noisy = 1'b1;
        adv(1);
        chk("b_glitch_lo_deb", b_deb, 1);
        adv(2);
        chk("b_glitch_lo_deb_late", b_deb, 1);
        b_noisy = 1'b0; p = cyc;
        qb.push_back('{is_rise: 1'b0, cyc: p + 3});
        adv(2);
        chk("b_fall_deb_before", b_deb, 1);
        adv(1);
        chk("b_fall_deb_after", b_deb, 0);
        adv(3);

        chk("a_events_drained", qa.size(), 0);
        chk("b_events_drained", qb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/debounce_edge_fsm.md
DEBOUNCE_EDGE_FSM -- requirements
Module: debounce_edge_fsm

Interface
REQ-001 The block SHALL have parameter STABLE_TICKS, default 10, meaning the number of consecutive enabled cycles an input level must persist before it is accepted (legal range 2..65535).
REQ-002 The block SHALL have port clk, input, 1, the single system clock; all state updates on its rising edge.
REQ-003 The block SHALL have port reset, input, 1, synchronous active-high reset.
REQ-004 The block SHALL have port en, input, 1, sample enable; when low, all state and counters hold.
REQ-005 The block SHALL have port noisy, input, 1, raw switch level, assumed already synchronised to clk.
REQ-006 The block SHALL have port debounced, output, 1, accepted stable level.
REQ-007 The block SHALL have port rise_tick, output, 1, one-cycle pulse when debounced goes 0->1.
REQ-008 The block SHALL have port fall_tick, output, 1, one-cycle pulse when debounced goes 1->0.
REQ-009 The block SHALL have port busy, output, 1, high while the FSM is in a WAIT state.

Function
REQ-010 The FSM SHALL have four states: ZERO, WAIT1, ONE and WAIT0.
REQ-011 In ZERO with en=1 and noisy=1, the FSM SHALL move to WAIT1 and clear the stability counter to 0.
REQ-012 In WAIT1 with en=1 and noisy=0, the FSM SHALL return to ZERO with no output change and no tick.
REQ-013 In WAIT1 with en=1 and noisy=1, the FSM SHALL move to ONE if the counter equals STABLE_TICKS-1, otherwise it SHALL increment the counter.
REQ-014 ONE/WAIT0 SHALL mirror ZERO/WAIT1 with noisy inverted: ONE->WAIT0 on noisy=0; WAIT0->ONE on noisy=1; WAIT0->ZERO at terminal count.
REQ-015 Acceptance latency SHALL be exactly STABLE_TICKS+1 consecutive enabled samples of the new level, counting the sample that leaves ZERO or ONE.
REQ-016 debounced SHALL be registered and equal 1 exactly when the state is ONE or WAIT0.
REQ-017 rise_tick SHALL be registered, high for exactly one cycle, on the cycle debounced first reads 1; fall_tick SHALL behave the same way for the transition to 0.
REQ-018 rise_tick and fall_tick SHALL never be high simultaneously, and no tick SHALL be emitted on an aborted WAIT.
REQ-019 When en=0, state, counter and debounced SHALL hold, and rise_tick/fall_tick SHALL be 0.
REQ-020 The stability counter SHALL be $clog2(STABLE_TICKS) bits wide and SHALL never wrap; the terminal compare takes priority over increment.
REQ-021 busy SHALL be combinational from state: 1 in WAIT1/WAIT0, 0 otherwise.

Reset
REQ-022 On a clk edge with reset=1, the block SHALL set state=ZERO, counter=0, debounced=0, rise_tick=0 and fall_tick=0, regardless of en or noisy.
REQ-023 Reset asserted mid-WAIT SHALL abandon the count; no tick SHALL follow the release of reset.
REQ-024 On the first edge after reset release, the FSM SHALL evaluate noisy normally from ZERO.

Structure
REQ-025 The state encoding (2-bit localparams ZERO=0, WAIT1=1, ONE=2, WAIT0=3) SHALL reside in a shared package debounce_pkg, which the edge-detector blocks also import.
REQ-026 The stability counter SHALL be a sub-module debounce_stable_counter with ports clk, reset, clear, inc and done (done = count==STABLE_TICKS-1).
REQ-027 The block SHALL contain no latches and no asynchronous logic.

Verification
REQ-028 Scenario: STABLE_TICKS=10, en=1, noisy held 1 from the first post-reset edge -> debounced rises after exactly 11 sampled edges; rise_tick is high for 1 cycle.
REQ-029 Scenario: noisy high for 6 cycles, low for 1, then high steadily -> the count restarts and debounced rises 11 samples after the re-entry, with exactly one rise_tick.
REQ-030 Scenario: from ONE, noisy toggles every 3 cycles for 40 cycles -> debounced stays 1, no ticks, busy pulses.
REQ-031 Scenario: en gated low for 5 cycles inside WAIT1 at count 4 -> completion is delayed by exactly 5 cycles and no tick occurs while en=0.
REQ-032 Scenario: reset pulsed at count 8 of WAIT1 with noisy=1 -> debounced=0, no tick; re-acceptance takes the full 11 samples.
REQ-033 Scenario: STABLE_TICKS=2 boundary -> debounced follows a 3-sample-stable input, and a 2-sample glitch is rejected.
